// File: rtl/sda_kernel_ctrl_irq.sv
// SDAccel-style kernel control/interrupt block: CTRL/GIE/IER/ISR registers with an IDLE/GO/BUSY start FSM.
// Register access acks one cycle after the request is sampled; go waits on action_go_holdoff, done is accepted only while BUSY.
module sda_kernel_ctrl_irq #(
  parameter int unsigned AUTO_RESTART_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_req,
  output logic        reg_ack,
  input  logic        reg_write_en,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        action_go_valid,
  input  logic        action_go_holdoff,
  input  logic        action_done_valid,
  output logic        action_done_stop,
  output logic        interrupt
);

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_GIE  = 2'd1;
  localparam logic [1:0] ADDR_IER  = 2'd2;
  localparam logic [1:0] ADDR_ISR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GO   = 2'd1,
    BUSY = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        ap_done;
  logic        auto_restart;
  logic        gie;
  logic [1:0]  ier;
  logic [1:0]  isr;

  logic        access;
  logic        wr_ctrl;
  logic        wr_gie;
  logic        wr_ier;
  logic        wr_isr;
  logic        rd_any;
  logic        rd_ctrl;
  logic        go_evt;
  logic        done_evt;
  logic [1:0]  isr_toggle;
  logic [31:0] rdata_mux;
  logic        unused_wdata;

  // Requests are only sampled outside the ack cycle, so a held request is seen once per ack.
  assign access  = reg_req & ~reg_ack;
  assign wr_ctrl = access &  reg_write_en & (reg_addr == ADDR_CTRL);
  assign wr_gie  = access &  reg_write_en & (reg_addr == ADDR_GIE);
  assign wr_ier  = access &  reg_write_en & (reg_addr == ADDR_IER);
  assign wr_isr  = access &  reg_write_en & (reg_addr == ADDR_ISR);
  assign rd_any  = access & ~reg_write_en;
  assign rd_ctrl = rd_any & (reg_addr == ADDR_CTRL);

  assign isr_toggle   = wr_isr ? reg_wdata[1:0] : 2'b00;
  assign unused_wdata = ^{reg_wdata[31:8], reg_wdata[6:2]};

  always_comb begin
    state_next       = state;
    action_go_valid  = 1'b0;
    action_done_stop = 1'b1;
    go_evt           = 1'b0;
    done_evt         = 1'b0;
    case (state)
      IDLE: begin
        if (wr_ctrl && reg_wdata[0]) begin
          state_next = GO;
        end
      end
      GO: begin
        action_go_valid = 1'b1;
        if (!action_go_holdoff) begin
          go_evt     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        action_done_stop = 1'b0;
        if (action_done_valid) begin
          done_evt   = 1'b1;
          state_next = auto_restart ? GO : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    rdata_mux = '0;
    case (reg_addr)
      ADDR_CTRL: begin
        rdata_mux[0] = (state == GO);
        rdata_mux[1] = ap_done;
        rdata_mux[2] = (state == IDLE);
        rdata_mux[7] = auto_restart;
      end
      ADDR_GIE: rdata_mux[0]   = gie;
      ADDR_IER: rdata_mux[1:0] = ier;
      ADDR_ISR: rdata_mux[1:0] = isr;
      default:  rdata_mux      = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
    end else begin
      state     <= state_next;
      reg_ack   <= access;
      reg_rdata <= rd_any ? rdata_mux : '0;
    end
  end

  // Done and go events take priority over a same-cycle read-clear or ISR toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ap_done      <= 1'b0;
      auto_restart <= 1'b0;
      gie          <= 1'b0;
      ier          <= 2'b00;
      isr          <= 2'b00;
      interrupt    <= 1'b0;
    end else begin
      if (done_evt) begin
        ap_done <= 1'b1;
      end else if (rd_ctrl) begin
        ap_done <= 1'b0;
      end
      if (wr_ctrl) begin
        auto_restart <= (AUTO_RESTART_EN != 0) && reg_wdata[7];
      end
      if (wr_gie) begin
        gie <= reg_wdata[0];
      end
      if (wr_ier) begin
        ier <= reg_wdata[1:0];
      end
      isr       <= (isr ^ isr_toggle) | {go_evt, done_evt};
      interrupt <= gie & (|(ier & isr));
    end
  end

endmodule

// File: tb/tb_sda_kernel_ctrl_irq.sv
// Randomized self-checking bench for sda_kernel_ctrl_irq; expectations come from the register/FSM rules.
module tb_sda_kernel_ctrl_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_req;
  logic        reg_ack;
  logic        reg_write_en;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        action_go_valid;
  logic        action_go_holdoff;
  logic        action_done_valid;
  logic        action_done_stop;
  logic        interrupt;

  int checks = 0;
  int errors = 0;

  sda_kernel_ctrl_irq #(.AUTO_RESTART_EN(1)) dut (
    .clk              (clk),
    .reset            (reset),
    .reg_req          (reg_req),
    .reg_ack          (reg_ack),
    .reg_write_en     (reg_write_en),
    .reg_addr         (reg_addr),
    .reg_wdata        (reg_wdata),
    .reg_rdata        (reg_rdata),
    .action_go_valid  (action_go_valid),
    .action_go_holdoff(action_go_holdoff),
    .action_done_valid(action_done_valid),
    .action_done_stop (action_done_stop),
    .interrupt        (interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic reg_access(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
    bit got;
    got   = 1'b0;
    rdata = '0;
    reg_req = 1'b1; reg_write_en = we; reg_addr = addr; reg_wdata = wdata;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (reg_ack) begin
        got   = 1'b1;
        rdata = reg_rdata;
      end
    end
    reg_req = 1'b0; reg_write_en = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL reg_ack_timeout: ack=0 after 20 cycles, required 1");
    end
  endtask

  task automatic reg_write(input logic [1:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    reg_access(1'b1, addr, wdata, dummy);
  endtask

  task automatic reg_read(input logic [1:0] addr, output logic [31:0] rdata);
    reg_access(1'b0, addr, 32'h0, rdata);
  endtask

  task automatic wait_busy();
    bit got;
    got = (action_done_stop == 1'b0);
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      got = (action_done_stop == 1'b0);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL busy_timeout: done_stop=1 after 20 cycles, required 0");
    end
  endtask

  task automatic done_pulse();
    action_done_valid = 1'b1;
    @(posedge clk); #1;
    action_done_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; reg_req = 1'b0; action_done_valid = 1'b0; action_go_holdoff = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({reg_ack, reg_rdata, action_go_valid, action_done_stop, interrupt} !== {1'b0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b rdata=%h go=%b stop=%b irq=%b, required 0 0 0 1 0",
               reg_ack, reg_rdata, action_go_valid, action_done_stop, interrupt);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reg_read(2'd0, rd);
    checks++;
    if (rd !== 32'h4) begin errors++; $display("FAIL reset_ctrl: got %h required %h", rd, 32'h4); end
    for (int a = 1; a < 4; a++) begin
      reg_read(a[1:0], rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL reset_reg%0d: got %h required 0", a, rd); end
    end
  endtask

  task automatic test_basic_run();
    logic [31:0] rd;
    reg_write(2'd0, 32'h1);
    checks++;
    if (action_go_valid !== 1'b1) begin errors++; $display("FAIL basic_go_high: got %b required 1", action_go_valid); end
    @(posedge clk); #1;
    checks++;
    if ({action_go_valid, action_done_stop} !== 2'b00) begin
      errors++; $display("FAIL basic_go_one_cycle: go=%b stop=%b required 0 0", action_go_valid, action_done_stop);
    end
    reg_read(2'd3, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL basic_isr_ready: got %h required %h", rd, 32'h2); end
    done_pulse();
    reg_read(2'd0, rd);
    checks++;
    if (rd !== 32'h6) begin errors++; $display("FAIL basic_ctrl_done: got %h required %h", rd, 32'h6); end
    reg_read(2'd0, rd);
    checks++;
    if (rd !== 32'h4) begin errors++; $display("FAIL basic_ctrl_cleared: got %h required %h", rd, 32'h4); end
    reg_read(2'd3, rd);
    checks++;
    if (rd !== 32'h3) begin errors++; $display("FAIL basic_isr_both: got %h required %h", rd, 32'h3); end
    reg_write(2'd3, 32'h3);
    done_pulse();
    reg_read(2'd3, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL idle_done_ignored_isr: got %h required 0", rd); end
    reg_read(2'd0, rd);
    checks++;
    if (rd !== 32'h4) begin errors++; $display("FAIL idle_done_ignored_ctrl: got %h required %h", rd, 32'h4); end
  endtask

  task automatic test_holdoff();
    logic [31:0] rd;
    int n;
    bit bad;
    n   = $urandom_range(12, 4);
    bad = 1'b0;
    action_go_holdoff = 1'b1;
    reg_write(2'd0, 32'h1);
    for (int i = 0; i < n; i++) begin
      if (action_go_valid !== 1'b1) bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL holdoff_go_dropped: go fell during %0d holdoff cycles, required 1", n); end
    reg_read(2'd0, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL holdoff_ctrl: got %h required %h", rd, 32'h1); end
    action_go_holdoff = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({action_go_valid, action_done_stop} !== 2'b00) begin
      errors++; $display("FAIL holdoff_release: go=%b stop=%b required 0 0", action_go_valid, action_done_stop);
    end
    reg_read(2'd0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL holdoff_busy_ctrl: got %h required 0", rd); end
    done_pulse();
    reg_read(2'd0, rd);
    reg_write(2'd3, 32'h3);
  endtask

  task automatic test_interrupt();
    logic [31:0] rd;
    reg_write(2'd1, 32'h1);
    reg_write(2'd2, 32'h1);
    reg_write(2'd0, 32'h1);
    wait_busy();
    action_done_valid = 1'b1;
    @(posedge clk); #1;
    action_done_valid = 1'b0;
    checks++;
    if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_early: got %b required 0", interrupt); end
    @(posedge clk); #1;
    checks++;
    if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_set: got %b required 1", interrupt); end
    reg_write(2'd3, 32'h1);
    checks++;
    if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_hold_after_clear: got %b required 1", interrupt); end
    @(posedge clk); #1;
    checks++;
    if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b required 0", interrupt); end
    reg_write(2'd3, 32'h2);
    reg_read(2'd0, rd);
    reg_write(2'd1, 32'h0);
    reg_write(2'd2, 32'h0);
  endtask

  task automatic test_auto_restart();
    logic [31:0] rd;
    bit bad;
    reg_write(2'd0, 32'h81);
    for (int r = 0; r < 3; r++) begin
      wait_busy();
      done_pulse();
      checks++;
      if (action_go_valid !== 1'b1) begin
        errors++; $display("FAIL auto_restart_go%0d: got %b required 1", r, action_go_valid);
      end
    end
    wait_busy();
    reg_write(2'd0, 32'h00);
    reg_read(2'd0, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL auto_clear_busy_ctrl: got %h required %h", rd, 32'h2); end
    done_pulse();
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (action_go_valid !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL auto_clear_restarted: go rose, required 0"); end
    reg_read(2'd0, rd);
    checks++;
    if (rd !== 32'h6) begin errors++; $display("FAIL auto_clear_idle_ctrl: got %h required %h", rd, 32'h6); end
    reg_write(2'd3, 32'h3);
  endtask

  task automatic test_collisions();
    logic [31:0] rd;
    reg_write(2'd0, 32'h1);
    wait_busy();
    reg_req = 1'b1; reg_write_en = 1'b0; reg_addr = 2'd0; action_done_valid = 1'b1;
    @(posedge clk); #1;
    action_done_valid = 1'b0;
    checks++;
    if ({reg_ack, reg_rdata} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL coll_read_ack: ack=%b rdata=%h required 1 0", reg_ack, reg_rdata);
    end
    reg_req = 1'b0;
    reg_read(2'd0, rd);
    checks++;
    if (rd !== 32'h6) begin errors++; $display("FAIL coll_done_wins_read: got %h required %h", rd, 32'h6); end
    reg_write(2'd0, 32'h1);
    wait_busy();
    reg_req = 1'b1; reg_write_en = 1'b1; reg_addr = 2'd3; reg_wdata = 32'h1; action_done_valid = 1'b1;
    @(posedge clk); #1;
    action_done_valid = 1'b0;
    reg_req = 1'b0; reg_write_en = 1'b0;
    reg_read(2'd3, rd);
    checks++;
    if (rd !== 32'h3) begin errors++; $display("FAIL coll_done_wins_toggle: got %h required %h", rd, 32'h3); end
    reg_read(2'd0, rd);
    reg_write(2'd3, 32'h3);
  endtask

  task automatic test_back_to_back();
    int acks;
    bit dbl;
    bit prev;
    @(posedge clk); #1;
    acks = 0; dbl = 1'b0; prev = 1'b0;
    reg_req = 1'b1; reg_write_en = 1'b0; reg_addr = 2'd1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (reg_ack) acks++;
      if (reg_ack && prev) dbl = 1'b1;
      prev = reg_ack;
    end
    reg_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (acks != 3 || dbl) begin
      errors++; $display("FAIL back_to_back_acks: got %0d acks (consecutive=%b) required 3 non-consecutive", acks, dbl);
    end
  endtask

  task automatic test_random_irq();
    logic [31:0] rd;
    logic [31:0] d;
    logic [1:0]  a;
    logic        m_gie;
    logic [1:0]  m_ier;
    logic [1:0]  m_isr;
    logic [31:0] exp_rd;
    logic        exp_irq;
    apply_reset();
    m_gie = 1'b0; m_ier = 2'b00; m_isr = 2'b00;
    for (int it = 0; it < 24; it++) begin
      a = 2'($urandom_range(3, 1));
      d = $urandom;
      reg_write(a, d);
      case (a)
        2'd1:    m_gie = d[0];
        2'd2:    m_ier = d[1:0];
        default: m_isr = m_isr ^ d[1:0];
      endcase
      exp_irq = m_gie && ((m_ier & m_isr) != 2'b00);
      @(posedge clk); #1;
      checks++;
      if (interrupt !== exp_irq) begin
        errors++; $display("FAIL rand_irq[%0d]: got %b required %b", it, interrupt, exp_irq);
      end
      reg_read(a, rd);
      exp_rd = (a == 2'd1) ? {31'h0, m_gie} : (a == 2'd2) ? {30'h0, m_ier} : {30'h0, m_isr};
      checks++;
      if (rd !== exp_rd) begin
        errors++; $display("FAIL rand_readback[%0d] addr %0d: got %h required %h", it, a, rd, exp_rd);
      end
    end
  endtask

  task automatic test_reset_busy();
    logic [31:0] rd;
    apply_reset();
    reg_write(2'd1, 32'h1);
    reg_write(2'd2, 32'h2);
    reg_write(2'd0, 32'h1);
    wait_busy();
    @(posedge clk); #1;
    checks++;
    if (interrupt !== 1'b1) begin errors++; $display("FAIL rst_busy_pre_irq: got %b required 1", interrupt); end
    action_done_valid = 1'b1;
    reg_req = 1'b1; reg_write_en = 1'b0; reg_addr = 2'd3;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({reg_ack, reg_rdata, action_go_valid, action_done_stop, interrupt} !== {1'b0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rst_busy_outputs: ack=%b rdata=%h go=%b stop=%b irq=%b, required 0 0 0 1 0",
               reg_ack, reg_rdata, action_go_valid, action_done_stop, interrupt);
    end
    @(posedge clk); #1;
    checks++;
    if (reg_ack !== 1'b0) begin errors++; $display("FAIL rst_pending_acked: got %b required 0", reg_ack); end
    reg_req = 1'b0; action_done_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (reg_ack !== 1'b0) begin errors++; $display("FAIL rst_release_ack: got %b required 0", reg_ack); end
    reg_read(2'd0, rd);
    checks++;
    if (rd !== 32'h4) begin errors++; $display("FAIL rst_busy_ctrl: got %h required %h", rd, 32'h4); end
    reg_read(2'd3, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_busy_isr: got %h required 0", rd); end
    reg_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_busy_gie: got %h required 0", rd); end
  endtask

  initial begin
    reset = 1'b1;
    reg_req = 1'b0; reg_write_en = 1'b0; reg_addr = 2'd0; reg_wdata = 32'h0;
    action_go_holdoff = 1'b0; action_done_valid = 1'b0;
    test_reset();
    test_basic_run();
    test_holdoff();
    test_interrupt();
    test_auto_restart();
    test_collisions();
    test_back_to_back();
    test_random_irq();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/sda_kernel_ctrl_irq.md
SDA_KERNEL_CTRL_IRQ -- requirements
Module: sda_kernel_ctrl_irq

Interface
REQ-001 Parameter: AUTO_RESTART_EN, default 1, enables writes to the ctrl auto_restart bit; when 0 the bit is held at 0.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  kernel clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 reg_req  in  1  register access request, held high until reg_ack.
REQ-006 reg_ack  out  1  one-cycle access acknowledge.
REQ-007 reg_write_en  in  1  1=write, 0=read; qualified by reg_req.
REQ-008 reg_addr  in  2  word address: 0=CTRL, 1=GIE, 2=IER, 3=ISR.
REQ-009 reg_wdata  in  32  write data.
REQ-010 reg_rdata  out  32  read data, valid only while reg_ack=1, 0 otherwise.
REQ-011 action_go_valid  out  1  start request to the action core.
REQ-012 action_go_holdoff  in  1  action core not ready to accept go.
REQ-013 action_done_valid  in  1  action core completion.
REQ-014 action_done_stop  out  1  block not ready to accept done.
REQ-015 interrupt  out  1  level interrupt to the SDAccel shell.

Function
REQ-016 Register handshake: the block SHALL sample reg_req=1 when reg_ack=0, assert reg_ack for exactly one cycle on the next cycle, and ignore reg_req during the ack cycle.
REQ-017 Write effects and reg_rdata SHALL take effect in the ack cycle; accesses are whole-word with no byte strobes.
REQ-018 CTRL read value: bit0 ap_start, bit1 ap_done, bit2 ap_idle, bit7 auto_restart; all other bits 0.
REQ-019 GIE read value: bit0 only. IER read value: bits1:0. ISR read value: bits1:0, where bit0 is done and bit1 is ready.
REQ-020 The FSM SHALL have states IDLE, GO and BUSY; ap_idle=1 only in IDLE; ap_start=1 only in GO.
REQ-021 IDLE->GO: on a CTRL write with wdata[0]=1; a wdata[0]=1 write in GO or BUSY SHALL be ignored.
REQ-022 GO: action_go_valid=1; when action_go_valid=1 and action_go_holdoff=0, move to BUSY and set ISR[1].
REQ-023 BUSY: action_done_stop=0; in all other states action_done_stop=1.
REQ-024 BUSY exit: when action_done_valid=1, set ap_done and ISR[0], then go to GO if auto_restart=1, else to IDLE.
REQ-025 action_done_valid outside BUSY SHALL be ignored.
REQ-026 ap_done SHALL be cleared by a CTRL read ack; if a done event occurs in the same cycle, set SHALL win.
REQ-027 A CTRL write SHALL update auto_restart from wdata[7] in any state; a CTRL write SHALL NOT alter ap_done.
REQ-028 An ISR write SHALL toggle each ISR bit whose wdata bit is 1; a set event in the same cycle SHALL win over a toggle of that bit.
REQ-029 GIE and IER writes SHALL replace their register contents.
REQ-030 interrupt SHALL be registered as GIE[0] & |(IER[1:0] & ISR[1:0]), so it reflects register state one cycle after any change.
REQ-031 Clearing auto_restart while BUSY SHALL cause the next done to go to IDLE.

Reset
REQ-032 On reset assertion the block SHALL enter IDLE immediately, including mid-operation.
REQ-033 On reset all registers SHALL be 0.
REQ-034 On reset the outputs SHALL be: reg_ack=0, reg_rdata=0, action_go_valid=0, action_done_stop=1, interrupt=0.
REQ-035 A request pending at reset SHALL be dropped and SHALL NOT be acknowledged.

Verification
REQ-036 Basic run: write CTRL=0x1 with holdoff=0 -> go_valid high 1 cycle, ISR=0x2; done pulse -> CTRL reads 0x6; a second CTRL read -> 0x4.
REQ-037 Holdoff: holdoff=1 for 10 cycles after start -> go_valid stays high and CTRL reads 0x1; release -> BUSY, CTRL=0x0.
REQ-038 Interrupt: GIE=1, IER=1, run -> interrupt=1 one cycle after ISR[0] sets; write ISR=0x1 -> interrupt=0 the following cycle.
REQ-039 Auto-restart: write CTRL=0x81 -> three go/done cycles with no further writes; write CTRL=0x00 mid-BUSY -> IDLE after the next done.
REQ-040 Collisions: done coincident with a CTRL read ack -> ap_done remains 1; done coincident with ISR write 0x1 -> ISR[0]=1.
REQ-041 Reset in BUSY with done_valid=1 -> all outputs at their reset values, and CTRL reads 0x4 after reset release.
